// File: rtl/flag_update_controller.sv
// Z/N/C flag owner: merges ALU/SETC/CLRC updates and saves/restores flags
// on a LIFO stack for interrupt entry and RTI, with a post-entry flush window.
module flag_update_controller #(
    parameter int STACK_DEPTH  = 4,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_alu_valid,
    input  logic [2:0] i_alu_mask,
    input  logic [2:0] i_alu_flags,
    input  logic       i_setc,
    input  logic       i_clrc,
    input  logic       i_int_req,
    input  logic       i_rti,
    output logic [2:0] o_flags,
    output logic       o_int_ack,
    output logic       o_rti_ack,
    output logic       o_busy,
    output logic [3:0] o_depth,
    output logic       o_stack_overflow,
    output logic       o_stack_underflow
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SAVE, FLUSH, RESTORE} state_t;

    state_t           state_reg;
    logic [2:0]       flags_reg;
    logic [3:0]       depth_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             int_ack_reg;
    logic             rti_ack_reg;
    logic             busy_reg;
    logic             overflow_reg;
    logic             underflow_reg;

    logic [2:0] flags_next;
    logic [2:0] top_entry;
    logic       push_en;
    logic [2:0] stack_q [STACK_DEPTH];

    assign push_en = (state_reg == SAVE) && (depth_reg < 4'(STACK_DEPTH));

    // Each stack slot is written only when it is the next free slot.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            logic [2:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push_en && depth_reg == 4'(gi)) begin
                    entry_reg <= flags_reg;
                end
            end
            assign stack_q[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        top_entry = 3'b000;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_reg == 4'(i + 1)) begin
                top_entry = stack_q[i];
            end
        end
    end

    // ALU merge first, then SETC/CLRC override C; both together leave C alone.
    always_comb begin
        flags_next = flags_reg;
        if (i_alu_valid) begin
            flags_next = (flags_reg & ~i_alu_mask) | (i_alu_flags & i_alu_mask);
        end
        if (i_setc && !i_clrc) begin
            flags_next[0] = 1'b1;
        end else if (i_clrc && !i_setc) begin
            flags_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            flags_reg     <= 3'b000;
            depth_reg     <= 4'd0;
            cnt_reg       <= '0;
            int_ack_reg   <= 1'b0;
            rti_ack_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            int_ack_reg <= 1'b0;
            rti_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_int_req) begin
                        state_reg <= SAVE;
                        busy_reg  <= 1'b1;
                    end else if (i_rti) begin
                        state_reg <= RESTORE;
                        busy_reg  <= 1'b1;
                    end else begin
                        flags_reg <= flags_next;
                    end
                end
                SAVE: begin
                    if (push_en) begin
                        depth_reg <= depth_reg + 4'd1;
                    end else begin
                        overflow_reg <= 1'b1;
                    end
                    int_ack_reg <= 1'b1;
                    cnt_reg     <= CNT_W'(FLUSH_CYCLES);
                    state_reg   <= FLUSH;
                end
                FLUSH: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                RESTORE: begin
                    if (depth_reg != 4'd0) begin
                        flags_reg <= top_entry;
                        depth_reg <= depth_reg - 4'd1;
                    end else begin
                        flags_reg     <= 3'b000;
                        underflow_reg <= 1'b1;
                    end
                    rti_ack_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_flags           = flags_reg;
    assign o_int_ack         = int_ack_reg;
    assign o_rti_ack         = rti_ack_reg;
    assign o_busy            = busy_reg;
    assign o_depth           = depth_reg;
    assign o_stack_overflow  = overflow_reg;
    assign o_stack_underflow = underflow_reg;

endmodule

// File: tb/tb_flag_update_controller.sv
// Directed bench for flag_update_controller: flag merging, save/flush,
// nested save/restore, stack overflow/underflow and mid-flush reset.
module tb_flag_update_controller;

    localparam int STACK_DEPTH  = 4;
    localparam int FLUSH_CYCLES = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_alu_valid;
    logic [2:0] i_alu_mask;
    logic [2:0] i_alu_flags;
    logic       i_setc;
    logic       i_clrc;
    logic       i_int_req;
    logic       i_rti;
    logic [2:0] o_flags;
    logic       o_int_ack;
    logic       o_rti_ack;
    logic       o_busy;
    logic [3:0] o_depth;
    logic       o_stack_overflow;
    logic       o_stack_underflow;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    flag_update_controller #(
        .STACK_DEPTH (STACK_DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_alu_valid      (i_alu_valid),
        .i_alu_mask       (i_alu_mask),
        .i_alu_flags      (i_alu_flags),
        .i_setc           (i_setc),
        .i_clrc           (i_clrc),
        .i_int_req        (i_int_req),
        .i_rti            (i_rti),
        .o_flags          (o_flags),
        .o_int_ack        (o_int_ack),
        .o_rti_ack        (o_rti_ack),
        .o_busy           (o_busy),
        .o_depth          (o_depth),
        .o_stack_overflow (o_stack_overflow),
        .o_stack_underflow(o_stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [2:0] mask, input logic [2:0] val);
        i_alu_valid = 1'b1;
        i_alu_mask  = mask;
        i_alu_flags = val;
        tick();
        i_alu_valid = 1'b0;
    endtask

    // Interrupt entry: SAVE then FLUSH_CYCLES of flush, back in IDLE on return.
    task automatic do_int(input string tag);
        i_int_req = 1'b1;
        tick();
        i_int_req = 1'b0;
        tick();
        check({tag, "_int_ack"}, 32'(o_int_ack), 32'd1);
        repeat (FLUSH_CYCLES) tick();
    endtask

    task automatic do_rti(input string tag);
        i_rti = 1'b1;
        tick();
        i_rti = 1'b0;
        tick();
        check({tag, "_rti_ack"}, 32'(o_rti_ack), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        i_alu_valid = 1'b0; i_alu_mask = 3'b000; i_alu_flags = 3'b000;
        i_setc = 1'b0; i_clrc = 1'b0; i_int_req = 1'b0; i_rti = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_flags", 32'(o_flags), 32'd0);
        check("rst_depth", 32'(o_depth), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_acks", 32'({o_int_ack, o_rti_ack}), 32'd0);
        check("rst_sticky", 32'({o_stack_overflow, o_stack_underflow}), 32'd0);

        // Masked merge leaves C untouched
        alu(3'b110, 3'b101);
        check("alu_mask110", 32'(o_flags), 32'b100);

        alu(3'b111, 3'b010);
        check("alu_load010", 32'(o_flags), 32'b010);
        i_setc = 1'b1;
        alu(3'b001, 3'b000);
        i_setc = 1'b0;
        check("alu_then_setc", 32'(o_flags), 32'b011);
        i_setc = 1'b1; i_clrc = 1'b1;
        tick();
        i_setc = 1'b0; i_clrc = 1'b0;
        check("setc_clrc_both", 32'(o_flags), 32'b011);
        i_clrc = 1'b1;
        tick();
        i_clrc = 1'b0;
        check("clrc_alone", 32'(o_flags), 32'b010);

        // Interrupt entry with ALU writes pending throughout the flush window
        alu(3'b111, 3'b101);
        i_int_req = 1'b1;
        tick();
        i_int_req = 1'b0;
        i_alu_valid = 1'b1; i_alu_mask = 3'b111; i_alu_flags = 3'b010;
        check("save_busy", 32'(o_busy), 32'd1);
        check("save_no_ack_yet", 32'(o_int_ack), 32'd0);
        tick();
        check("flush1_ack", 32'(o_int_ack), 32'd1);
        check("flush1_depth", 32'(o_depth), 32'd1);
        check("flush1_busy", 32'(o_busy), 32'd1);
        tick();
        check("flush2_ack_pulse", 32'(o_int_ack), 32'd0);
        check("flush2_busy", 32'(o_busy), 32'd1);
        tick();
        check("flush3_busy", 32'(o_busy), 32'd1);
        tick();
        check("flush_done_busy", 32'(o_busy), 32'd0);
        check("flush_blocked", 32'(o_flags), 32'b101);
        i_alu_valid = 1'b0;
        do_rti("pop101");
        check("pop101_flags", 32'(o_flags), 32'b101);
        check("pop101_depth", 32'(o_depth), 32'd0);

        // Two nested saves then two restores
        alu(3'b111, 3'b001);
        do_int("nest1");
        check("nest1_depth", 32'(o_depth), 32'd1);
        alu(3'b111, 3'b110);
        do_int("nest2");
        check("nest2_depth", 32'(o_depth), 32'd2);
        alu(3'b111, 3'b000);
        check("nest_cleared", 32'(o_flags), 32'b000);
        do_rti("rti1");
        check("rti1_flags", 32'(o_flags), 32'b110);
        check("rti1_depth", 32'(o_depth), 32'd1);
        do_rti("rti2");
        check("rti2_flags", 32'(o_flags), 32'b001);
        check("rti2_depth", 32'(o_depth), 32'd0);
        check("nest_no_sticky", 32'({o_stack_overflow, o_stack_underflow}), 32'd0);

        // Overflow: STACK_DEPTH+1 entries
        for (int i = 0; i < STACK_DEPTH; i++) do_int("fill");
        check("full_depth", 32'(o_depth), 32'(STACK_DEPTH));
        check("full_no_ovf", 32'(o_stack_overflow), 32'd0);
        do_int("ovf");
        check("ovf_sticky", 32'(o_stack_overflow), 32'd1);
        check("ovf_depth", 32'(o_depth), 32'(STACK_DEPTH));
        for (int i = 0; i < STACK_DEPTH; i++) do_rti("drain");
        check("drain_flags", 32'(o_flags), 32'b001);
        check("drain_depth", 32'(o_depth), 32'd0);

        // Underflow zeroes the flags
        alu(3'b111, 3'b111);
        do_rti("unf");
        check("unf_flags", 32'(o_flags), 32'b000);
        check("unf_sticky", 32'(o_stack_underflow), 32'd1);
        check("ovf_still_set", 32'(o_stack_overflow), 32'd1);

        // int_req beats rti; reset in second flush cycle
        i_int_req = 1'b1; i_rti = 1'b1;
        tick();
        i_int_req = 1'b0; i_rti = 1'b0;
        check("prio_save_busy", 32'(o_busy), 32'd1);
        tick();
        check("prio_int_ack", 32'(o_int_ack), 32'd1);
        check("prio_no_rti_ack", 32'(o_rti_ack), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_flags", 32'(o_flags), 32'd0);
        check("mid_rst_depth", 32'(o_depth), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_sticky", 32'({o_stack_overflow, o_stack_underflow}), 32'd0);
        alu(3'b111, 3'b011);
        check("post_rst_idle", 32'(o_flags), 32'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
